// File: rtl/csi_capture_ctrl_if.sv
// 32-bit AXI-Stream style bundle used for both the upstream CSI feed and the DMA-facing output.
interface csi_capture_ctrl_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/csi_capture_ctrl.sv
// CSI frame capture controller: aligns to frame boundaries, decimates, prepends a sequence header
// and forwards whole frames to the DMA stream with zero-latency pass-through.
module csi_capture_ctrl #(
    parameter int          FRAME_LEN = 64,
    parameter logic [15:0] HDR_TAG   = 16'hC51A
) (
    input  logic                   clk_in,
    input  logic                   aresetn,
    input  logic                   arm_in,
    input  logic                   stop_in,
    input  logic                   continuous_in,
    input  logic [7:0]             decim_in,
    input  logic [15:0]            budget_in,
    csi_capture_ctrl_if.slave      csi_axis,
    csi_capture_ctrl_if.master     out_axis,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   len_err_out,
    output logic [15:0]            frames_captured_out,
    output logic [15:0]            frames_dropped_out
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_SOF = 3'd1;
    localparam logic [2:0] HEADER   = 3'd2;
    localparam logic [2:0] PASS     = 3'd3;
    localparam logic [2:0] RESYNC   = 3'd4;
    localparam logic [2:0] DISCARD  = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]        state;
    logic              sof;
    logic [15:0]       seq;
    logic [7:0]        phase;
    logic [BEAT_W-1:0] beat;
    logic [15:0]       captured;
    logic [15:0]       dropped;
    logic              len_err;
    logic              stop_pend;
    logic              cfg_cont;
    logic [7:0]        cfg_decim;
    logic [15:0]       cfg_budget;

    logic              in_hs;
    logic              out_hs;
    logic              beat_last;
    logic [15:0]       captured_inc;
    logic              stop_now;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic budget_hit(input logic cont, input logic [15:0] cnt,
                                        input logic [15:0] budget);
        return !cont && (cnt == budget);
    endfunction

    assign in_hs        = csi_axis.tvalid && csi_axis.tready;
    assign out_hs       = out_axis.tvalid && out_axis.tready;
    assign beat_last    = (beat == LAST_BEAT);
    assign captured_inc = sat_inc(captured);
    assign stop_now     = stop_pend || stop_in;

    // Handshake steering: only HEADER and PASS talk to the output; everything else sinks input.
    always_comb begin
        csi_axis.tready = 1'b1;
        out_axis.tvalid = 1'b0;
        out_axis.tdata  = '0;
        out_axis.tlast  = 1'b0;
        case (state)
            WAIT_SOF: begin
                // Hold the first beat of a frame while the keep/drop decision is made.
                csi_axis.tready = !sof;
            end
            HEADER: begin
                csi_axis.tready = 1'b0;
                out_axis.tvalid = 1'b1;
                out_axis.tdata  = {HDR_TAG, seq};
            end
            PASS: begin
                csi_axis.tready = out_axis.tready;
                out_axis.tvalid = csi_axis.tvalid;
                out_axis.tdata  = csi_axis.tdata;
                out_axis.tlast  = csi_axis.tlast || beat_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!aresetn) begin
            state      <= IDLE;
            sof        <= 1'b1;
            seq        <= '0;
            phase      <= '0;
            beat       <= '0;
            captured   <= '0;
            dropped    <= '0;
            len_err    <= 1'b0;
            stop_pend  <= 1'b0;
            cfg_cont   <= 1'b0;
            cfg_decim  <= '0;
            cfg_budget <= '0;
        end else begin
            if (in_hs) begin
                sof <= csi_axis.tlast;
            end

            case (state)
                IDLE, DONE: begin
                    if (arm_in) begin
                        cfg_cont   <= continuous_in;
                        cfg_decim  <= decim_in;
                        cfg_budget <= budget_in;
                        captured   <= '0;
                        dropped    <= '0;
                        seq        <= '0;
                        phase      <= '0;
                        beat       <= '0;
                        len_err    <= 1'b0;
                        stop_pend  <= 1'b0;
                        state      <= (!continuous_in && budget_in == 16'd0) ? DONE : WAIT_SOF;
                    end
                end

                WAIT_SOF: begin
                    if (stop_in) begin
                        state <= DONE;
                    end else if (sof && csi_axis.tvalid) begin
                        if (phase == 8'd0) begin
                            state <= HEADER;
                        end else begin
                            state   <= DISCARD;
                            dropped <= sat_inc(dropped);
                        end
                        phase <= (phase == cfg_decim) ? 8'd0 : phase + 8'd1;
                    end
                end

                HEADER: begin
                    if (stop_in) begin
                        stop_pend <= 1'b1;
                    end
                    if (out_hs) begin
                        state <= PASS;
                        seq   <= seq + 16'd1;
                        beat  <= '0;
                    end
                end

                PASS: begin
                    if (stop_in) begin
                        stop_pend <= 1'b1;
                    end
                    if (in_hs) begin
                        beat <= beat + BEAT_W'(1);
                        if (csi_axis.tlast || beat_last) begin
                            captured <= captured_inc;
                            // Early tlast and missing tlast are both length errors.
                            if (csi_axis.tlast != beat_last) begin
                                len_err <= 1'b1;
                            end
                            if (!csi_axis.tlast) begin
                                state <= RESYNC;
                            end else if (stop_now || budget_hit(cfg_cont, captured_inc, cfg_budget)) begin
                                state <= DONE;
                            end else begin
                                state <= WAIT_SOF;
                            end
                        end
                    end
                end

                RESYNC: begin
                    if (stop_in) begin
                        stop_pend <= 1'b1;
                    end
                    if (in_hs && csi_axis.tlast) begin
                        state <= (stop_now || budget_hit(cfg_cont, captured, cfg_budget)) ? DONE : WAIT_SOF;
                    end
                end

                DISCARD: begin
                    if (stop_in) begin
                        stop_pend <= 1'b1;
                    end
                    if (in_hs && csi_axis.tlast) begin
                        state <= stop_now ? DONE : WAIT_SOF;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy_out            = (state == WAIT_SOF) || (state == HEADER) || (state == PASS) ||
                                 (state == RESYNC) || (state == DISCARD);
    assign done_out            = (state == DONE);
    assign len_err_out         = len_err;
    assign frames_captured_out = captured;
    assign frames_dropped_out  = dropped;

    // A presented header stays presented, unchanged, until the DMA side takes it.
    a_header_held: assert property (@(posedge clk_in) disable iff (!aresetn)
        (state == HEADER && !out_axis.tready) |=> (state == HEADER));

    a_busy_done_exclusive: assert property (@(posedge clk_in) !(busy_out && done_out));

endmodule
